// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issuing master: ALU select codes,
// MIPS funct encodings and the sequencer state enum.
package alu_pkg;

  localparam logic [3:0] SEL_ADD   = 4'b0000;
  localparam logic [3:0] SEL_SUB   = 4'b0001;
  localparam logic [3:0] SEL_MUL   = 4'b0010;
  localparam logic [3:0] SEL_NOT   = 4'b0101;
  localparam logic [3:0] SEL_AND   = 4'b0110;
  localparam logic [3:0] SEL_OR    = 4'b0111;
  localparam logic [3:0] SEL_SHL1  = 4'b1000;
  localparam logic [3:0] SEL_SHR1  = 4'b1001;
  localparam logic [3:0] SEL_PASSA = 4'b1101;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Maps a MIPS R-type funct/shamt pair onto the ALU step program:
// select for the first step, select for the remaining steps, and step count.
module alu_funct_decode
  import alu_pkg::*;
#(
  parameter int SHW = 5
) (
  input  logic [5:0]     funct,
  input  logic [SHW-1:0] shamt,
  output logic [3:0]     sel_first,
  output logic [3:0]     sel_second,
  output logic [SHW-1:0] steps,
  output logic           use_b_as_acc,
  output logic           illegal
);

  always_comb begin
    sel_first    = SEL_PASSA;
    sel_second   = SEL_PASSA;
    steps        = SHW'(1);
    use_b_as_acc = 1'b0;
    illegal      = 1'b0;
    case (funct)
      FN_ADD:  begin sel_first = SEL_ADD; sel_second = SEL_ADD; end
      FN_SUB:  begin sel_first = SEL_SUB; sel_second = SEL_SUB; end
      FN_MULT: begin sel_first = SEL_MUL; sel_second = SEL_MUL; end
      FN_AND:  begin sel_first = SEL_AND; sel_second = SEL_AND; end
      FN_OR:   begin sel_first = SEL_OR;  sel_second = SEL_OR;  end
      FN_NOR: begin
        sel_first  = SEL_OR;
        sel_second = SEL_NOT;
        steps      = SHW'(2);
      end
      FN_SLL, FN_SRL: begin
        use_b_as_acc = 1'b1;
        // a zero shift still needs one step to move rt into the result
        if (shamt != '0) begin
          sel_first  = (funct == FN_SLL) ? SEL_SHL1 : SEL_SHR1;
          sel_second = sel_first;
          steps      = shamt;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issuing master for a combinational 32-bit ALU: accepts one R-type op,
// steps it through the ALU and hands back a registered result.
//   state | meaning
//   IDLE  | ready for a new request
//   EXEC  | driving ALU, one step per cycle, cnt_q steps left
//   DONE  | result held until res_ready
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_select,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_zero,
  output logic             res_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, op_b_q, op_b_d, result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d, sel2_q, sel2_d;
  logic             zero_q, zero_d, err_q, err_d;

  logic [3:0]     dec_first, dec_second;
  logic [SHW-1:0] dec_steps;
  logic           dec_use_b, dec_illegal;

  alu_funct_decode #(.SHW(SHW)) u_decode (
    .funct        (funct),
    .shamt        (shamt),
    .sel_first    (dec_first),
    .sel_second   (dec_second),
    .steps        (dec_steps),
    .use_b_as_acc (dec_use_b),
    .illegal      (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      op_b_q   <= '0;
      cnt_q    <= '0;
      sel_q    <= SEL_PASSA;
      sel2_q   <= SEL_PASSA;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      op_b_q   <= op_b_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sel2_q   <= sel2_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    sel2_d     = sel2_q;
    result_d   = result_q;
    zero_d     = zero_q;
    err_d      = err_q;
    alu_a      = acc_q;
    alu_b      = op_b_q;
    alu_select = SEL_PASSA;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d  = dec_use_b ? opnd_b : opnd_a;
          op_b_d = opnd_b;
          cnt_d  = dec_steps;
          sel_d  = dec_first;
          sel2_d = dec_second;
          if (dec_illegal) begin
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        alu_select = sel_q;
        acc_d      = alu_out;
        cnt_d      = cnt_q - SHW'(1);
        sel_d      = sel2_q;
        if (cnt_q == SHW'(1)) begin
          result_d = alu_out;
          zero_d   = (alu_out == '0);
          err_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign result    = result_q;
  assign res_zero  = zero_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural combinational ALU attached.
module tb_alu_issue;

  localparam logic [3:0] S_ADD = 4'b0000, S_SUB = 4'b0001, S_MUL = 4'b0010,
                         S_NOT = 4'b0101, S_AND = 4'b0110, S_OR = 4'b0111,
                         S_SHL = 4'b1000, S_SHR = 4'b1001, S_PA = 4'b1101;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] opnd_a = '0, opnd_b = '0;
  logic        in_ready, res_valid, res_zero, res_err;
  logic [31:0] alu_a, alu_b, alu_out, result;
  logic [3:0]  alu_select;

  int errors = 0;
  int checks = 0;

  alu_issue #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .res_zero(res_zero), .res_err(res_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_select)
      S_ADD:   alu_out = alu_a + alu_b;
      S_SUB:   alu_out = alu_a - alu_b;
      S_MUL:   alu_out = alu_a * alu_b;
      S_NOT:   alu_out = ~alu_a;
      S_AND:   alu_out = alu_a & alu_b;
      S_OR:    alu_out = alu_a | alu_b;
      S_SHL:   alu_out = alu_a << 1;
      S_SHR:   alu_out = alu_a >> 1;
      S_PA:    alu_out = alu_a;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          lat;
    logic [3:0]  sel_first;
    logic [3:0]  sel_last;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_result(input string nm, output int n, output logic [3:0] sf,
                             output logic [3:0] sl);
    n  = 1;
    sf = 4'hF;
    sl = 4'hF;
    while (!res_valid && n < 100) begin
      if (n == 1) sf = alu_select;
      sl = alu_select;
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) chk({nm, " timeout"}, 32'(res_valid), 32'd1);
  endtask

  task automatic handoff(input string nm);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({nm, " valid_drop"}, 32'(res_valid), 32'd0);
    chk({nm, " ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n;
    logic [3:0] sf, sl;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    funct = v.funct; shamt = v.shamt; opnd_a = v.a; opnd_b = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(nm, n, sf, sl);
    chk({nm, " latency"}, 32'(n), 32'(v.lat));
    chk({nm, " result"}, result, v.res);
    chk({nm, " err"}, 32'(res_err), 32'(v.err));
    if (!v.err) begin
      chk({nm, " zero"}, 32'(res_zero), 32'(v.zero));
      chk({nm, " sel_first"}, 32'(sf), 32'(v.sel_first));
      chk({nm, " sel_last"}, 32'(sl), 32'(v.sel_last));
    end
    @(negedge clk);
    chk({nm, " hold"}, result, v.res);
    handoff(nm);
  endtask

  initial begin
    int n;
    logic [3:0] sf, sl;
    vec_t v;

    vecs[0]  = '{6'b100000, 5'd0,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 2,  S_ADD, S_ADD};
    vecs[1]  = '{6'b100010, 5'd0,  32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 2,  S_SUB, S_SUB};
    vecs[2]  = '{6'b011000, 5'd0,  32'd6,          32'd7,          32'd42,         1'b0, 1'b0, 2,  S_MUL, S_MUL};
    vecs[3]  = '{6'b011000, 5'd0,  32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 1'b0, 2,  S_MUL, S_MUL};
    vecs[4]  = '{6'b100100, 5'd0,  32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1'b0, 1'b0, 2,  S_AND, S_AND};
    vecs[5]  = '{6'b100101, 5'd0,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0, 1'b0, 2,  S_OR,  S_OR};
    vecs[6]  = '{6'b100111, 5'd0,  32'hF0F0_0000,  32'h0F0F_0000,  32'h0000_FFFF,  1'b0, 1'b0, 3,  S_OR,  S_NOT};
    vecs[7]  = '{6'b000000, 5'd31, 32'h0000_1234,  32'h0000_0001,  32'h8000_0000,  1'b0, 1'b0, 32, S_SHL, S_SHL};
    vecs[8]  = '{6'b000010, 5'd4,  32'h0000_0000,  32'h8000_0000,  32'h0800_0000,  1'b0, 1'b0, 5,  S_SHR, S_SHR};
    vecs[9]  = '{6'b000000, 5'd0,  32'h0000_DEAD,  32'h0000_0055,  32'h0000_0055,  1'b0, 1'b0, 2,  S_PA,  S_PA};
    vecs[10] = '{6'b000010, 5'd1,  32'h0000_0000,  32'h0000_0001,  32'd0,          1'b1, 1'b0, 2,  S_SHR, S_SHR};
    vecs[11] = '{6'b100000, 5'd0,  32'hFFFF_FFFF,  32'h0000_0001,  32'd0,          1'b1, 1'b0, 2,  S_ADD, S_ADD};
    vecs[12] = '{6'b100010, 5'd0,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0, 2,  S_SUB, S_SUB};
    vecs[13] = '{6'b101010, 5'd0,  32'd1,          32'd2,          32'd0,          1'b0, 1'b1, 1,  S_PA,  S_PA};

    #12;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst zero", 32'(res_zero), 32'd0);
    chk("rst err", 32'(res_err), 32'd0);
    chk("rst select", 32'(alu_select), 32'(S_PA));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_op(vecs[i], i);

    // illegal op stalled by consumer, then a request overlapping the handoff
    @(negedge clk);
    funct = 6'b101010; opnd_a = 32'd4; opnd_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall latency", 32'(res_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d valid", c), 32'(res_valid), 32'd1);
      chk($sformatf("stall%0d result", c), result, 32'd0);
      chk($sformatf("stall%0d err", c), 32'(res_err), 32'd1);
      chk($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    funct = 6'b100000; opnd_a = 32'd1; opnd_b = 32'd2; in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("overlap not_accepted", 32'(in_ready), 32'd1);
    chk("overlap valid_drop", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overlap accepted", 32'(in_ready), 32'd0);
    wait_result("overlap", n, sf, sl);
    chk("overlap latency", 32'(n), 32'd2);
    chk("overlap result", result, 32'd3);
    chk("overlap err", 32'(res_err), 32'd0);
    handoff("overlap");

    // reset in the second EXEC cycle of a 4-step shift
    @(negedge clk);
    funct = 6'b000010; shamt = 5'd4; opnd_a = 32'd0; opnd_b = 32'h8000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", 32'(in_ready), 32'd0);
    chk("midrst acc", alu_a, 32'h4000_0000);
    chk("midrst sel", 32'(alu_select), 32'(S_SHR));
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst res_valid", 32'(res_valid), 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst zero", 32'(res_zero), 32'd0);
    chk("midrst err", 32'(res_err), 32'd0);
    chk("midrst alu_a", alu_a, 32'd0);
    chk("midrst alu_b", alu_b, 32'd0);
    chk("midrst select", 32'(alu_select), 32'(S_PA));
    @(negedge clk);
    rst_n = 1'b1;
    v = '{6'b100000, 5'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 2, S_ADD, S_ADD};
    run_op(v, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
